// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// uart_rx_ctrl: 16x baud tick generator, show-ahead receive FIFO and status for the UART receiver.
// Optional character timeout is built when UART_RX_TIMEOUT_EN is defined.  Rev 1.0
module uart_rx_ctrl #(
  parameter int          DEPTH         = 16,
  parameter logic [15:0] DEFAULT_DIV   = 16'd27,
  parameter int          TIMEOUT_TICKS = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              div_value,
  input  logic                     div_load,
  output logic                     baud_tick_16x,
  input  logic [7:0]               rx_data_in,
  input  logic                     rx_ready_in,
  input  logic                     rx_error_in,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               err_count,
  input  logic                     clear_status,
  output logic                     rx_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0] divisor;
  logic [15:0] tick_cnt;
  logic [15:0] load_val;
  logic [15:0] reload_val;

  // Divisors of 0 and 1 both collapse to a reload of 0, i.e. a tick every cycle.
  assign load_val   = (div_value <= 16'd1) ? 16'd0 : div_value - 16'd1;
  assign reload_val = (divisor   <= 16'd1) ? 16'd0 : divisor   - 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor       <= DEFAULT_DIV;
      tick_cnt      <= 16'd0;
      baud_tick_16x <= 1'b0;
    end else begin
      baud_tick_16x <= (tick_cnt == 16'd0) && !div_load;
      if (div_load) begin
        divisor  <= div_value;
        tick_cnt <= load_val;
      end else if (tick_cnt == 16'd0) begin
        tick_cnt <= reload_val;
      end else begin
        tick_cnt <= tick_cnt - 16'd1;
      end
    end
  end

  logic rdy_q;
  logic err_q;
  logic push_ev;
  logic err_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdy_q <= rx_ready_in;
      err_q <= rx_error_in;
    end
  end

  // A byte flagged by the receiver in its ready cycle is discarded.
  assign push_ev = rx_ready_in & ~rdy_q & ~rx_error_in;
  assign err_ev  = rx_error_in & ~err_q;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_acc;
  logic          drop;

  assign empty    = (fifo_count == CW'(0));
  assign full     = (fifo_count == CW'(DEPTH));
  assign m_valid  = ~empty;
  assign pop      = m_valid & m_ready;
  assign push_acc = push_ev & (~full | pop);
  assign drop     = push_ev & full & ~pop;
  assign m_data   = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= rx_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      case ({push_acc, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // New events take priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (drop)              overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;

      if (err_ev) begin
        if (clear_status)             err_count <= 8'd1;
        else if (err_count != 8'hFF)  err_count <= err_count + 8'd1;
      end else if (clear_status) begin
        err_count <= 8'd0;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);

  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_nxt;

  always_comb begin
    idle_nxt = idle_cnt;
    if (push_ev || pop || empty) begin
      idle_nxt = '0;
    end else if (baud_tick_16x && (idle_cnt != IW'(TIMEOUT_TICKS))) begin
      idle_nxt = idle_cnt + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt   <= '0;
      rx_timeout <= 1'b0;
    end else begin
      idle_cnt   <= idle_nxt;
      rx_timeout <= (idle_nxt == IW'(TIMEOUT_TICKS));
    end
  end
`else
  assign rx_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// tb_uart_rx_ctrl: directed and randomized checks of uart_rx_ctrl against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div_value;
  logic        div_load;
  logic        baud_tick_16x;
  logic [7:0]  rx_data_in;
  logic        rx_ready_in;
  logic        rx_error_in;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [7:0]  err_count;
  logic        clear_status;
  logic        rx_timeout;

  uart_rx_ctrl #(.DEPTH(DEPTH), .DEFAULT_DIV(16'd27), .TIMEOUT_TICKS(640)) dut (
    .clk(clk), .rst(rst),
    .div_value(div_value), .div_load(div_load), .baud_tick_16x(baud_tick_16x),
    .rx_data_in(rx_data_in), .rx_ready_in(rx_ready_in), .rx_error_in(rx_error_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .overflow(overflow), .err_count(err_count),
    .clear_status(clear_status), .rx_timeout(rx_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ovf;
  int         m_errc;
  logic       m_prev_rdy;
  logic       m_prev_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf      = 1'b0;
    m_errc     = 0;
    m_prev_rdy = 1'b0;
    m_prev_err = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, then compare at the following negedge.
  task automatic step(input logic r, input logic [7:0] d, input logic e, input logic mr, input logic clr);
    bit pop_e, push_e, rise_e, drop_e;
    rx_ready_in  = r;
    rx_data_in   = d;
    rx_error_in  = e;
    m_ready      = mr;
    clear_status = clr;
    pop_e  = (q.size() != 0) && mr;
    push_e = r && !m_prev_rdy && !e;
    rise_e = e && !m_prev_err;
    drop_e = 1'b0;
    if (pop_e) void'(q.pop_front());
    if (push_e) begin
      if (q.size() < DEPTH) q.push_back(d);
      else drop_e = 1'b1;
    end
    if (drop_e)   m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (rise_e)   m_errc = clr ? 1 : ((m_errc < 255) ? m_errc + 1 : 255);
    else if (clr) m_errc = 0;
    m_prev_rdy = r;
    m_prev_err = e;
    @(negedge clk);
    chk("m_valid",    m_valid,    (q.size() != 0));
    chk("m_data",     m_data,     (q.size() != 0) ? q[0] : 8'h00);
    chk("fifo_count", fifo_count, q.size());
    chk("overflow",   overflow,   m_ovf);
    chk("err_count",  err_count,  m_errc);
`ifndef UART_RX_TIMEOUT_EN
    chk("rx_timeout_off", rx_timeout, 1'b0);
`endif
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    step(1'b0, d, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int last;
    int nt;
    int k;
    logic r_cur;
    int mr_pct;

    rst = 1'b1;
    div_value = 16'd0; div_load = 1'b0;
    rx_data_in = 8'h00; rx_ready_in = 1'b0; rx_error_in = 1'b0;
    m_ready = 1'b0; clear_status = 1'b0;
    model_reset();
    #23;
    chk("rst_tick",     baud_tick_16x, 1'b0);
    chk("rst_valid",    m_valid,       1'b0);
    chk("rst_data",     m_data,        8'h00);
    chk("rst_count",    fifo_count,    5'd0);
    chk("rst_overflow", overflow,      1'b0);
    chk("rst_errc",     err_count,     8'd0);
    chk("rst_timeout",  rx_timeout,    1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Default divisor: ticks every 27 cycles
    last = -1; nt = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (baud_tick_16x) begin
        if (last >= 0) chk("tick_period27", c - last, 27);
        last = c;
        nt++;
      end
    end
    chk("tick_seen", (nt >= 4), 1'b1);

    // Divisor load of 4
    @(negedge clk);
    div_value = 16'd4; div_load = 1'b1;
    @(posedge clk); #1;
    chk("tick_in_load", baud_tick_16x, 1'b0);
    div_load = 1'b0;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!baud_tick_16x && k < 50);
    chk("tick_after_load", k, 4);
    for (int j = 0; j < 2; j++) begin
      k = 0;
      do begin
        @(posedge clk); #1; k++;
      end while (!baud_tick_16x && k < 50);
      chk("tick_period4", k, 4);
    end
    @(negedge clk);

    // Level-held ready yields a single push
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_count", fifo_count, 5'd1);
    chk("a5_data",  m_data,     8'hA5);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_nodup", fifo_count, 5'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("a5_drained", m_valid, 1'b0);

    // Fill, overflow, drain in order
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_count", fifo_count, 5'd16);
    push_byte(8'hFF);
    chk("ovf_count", fifo_count, 5'd16);
    chk("ovf_flag",  overflow,   1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", m_data, i);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", m_valid, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", overflow, 1'b0);

    // Second fill wraps pointers; push and pop together while full
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    chk("full_pp_count", fifo_count, 5'd16);
    chk("full_pp_ovf",   overflow,   1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      chk("wrap_order", m_data, 8'h20 + 8'(i));
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("pp_last_byte", m_data, 8'h55);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("pp_empty", m_valid, 1'b0);

    // Push and pop together at count 1
    push_byte(8'h11);
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    chk("one_pp_count", fifo_count, 5'd1);
    chk("one_pp_data",  m_data,     8'h22);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Error counter saturation and clear/event collision
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    chk("err_sat", err_count, 8'd255);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("err_clear_win", err_count, 8'd1);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("err_byte_dropped", fifo_count, 5'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    r_cur = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      mr_pct = (i < 600) ? 20 : 75;
      if ($urandom_range(0, 2) == 0) r_cur = ~r_cur;
      step(r_cur, 8'($urandom()), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 99) < mr_pct), ($urandom_range(0, 59) == 0));
    end

    // Mid-operation asynchronous reset
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push_byte(8'h01); push_byte(8'h02);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #2;
    chk("mrst_count", fifo_count, 5'd0);
    chk("mrst_valid", m_valid,    1'b0);
    chk("mrst_ovf",   overflow,   1'b0);
    chk("mrst_errc",  err_count,  8'd0);
    model_reset();
    rx_error_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_TIMEOUT_EN
    div_value = 16'd1; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    repeat (3) @(negedge clk);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!rx_timeout && k < 1000);
    chk("timeout_ticks", k, 640);
    @(negedge clk);
    chk("timeout_held", rx_timeout, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("timeout_clear", rx_timeout, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART receiver. Generates the receiver's 16x oversampling tick from a programmable divisor, captures completed bytes from the receiver's handshake into a show-ahead FIFO, and exposes them on a valid/ready stream. Also maintains overflow and framing-error status for the host register block, plus an optional character-timeout indication.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, minimum 2
DEFAULT_DIV, 16'd27, divisor loaded at reset (clk cycles per 16x tick)
TIMEOUT_TICKS, 640, 16x ticks of inactivity before rx_timeout (4 chars x 10 bits x 16)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
div_value  input  16  new baud divisor
div_load  input  1  single-cycle strobe; latch div_value
baud_tick_16x  output  1  one-clk pulse per oversample period, to receiver
rx_data_in  input  8  receiver data byte
rx_ready_in  input  1  receiver byte-ready; may stay high for several cycles
rx_error_in  input  1  receiver framing/start error pulse
m_data  output  8  FIFO head byte
m_valid  output  1  FIFO non-empty
m_ready  input  1  consumer accepts m_data when m_valid is high
fifo_count  output  $clog2(DEPTH)+1  bytes held
overflow  output  1  sticky: byte dropped because FIFO was full
err_count  output  8  saturating count of receiver errors
clear_status  input  1  single-cycle strobe; clears overflow and err_count
rx_timeout  output  1  character-timeout flag

Behaviour:
- Reset (async): divisor=DEFAULT_DIV, tick counter=0, baud_tick_16x=0, FIFO empty, m_valid=0, m_data=0, fifo_count=0, overflow=0, err_count=0, rx_timeout=0, edge-detect registers=0.
- Baud generator:
  - Down-counter. When it is 0, baud_tick_16x=1 for exactly one cycle and the counter reloads divisor-1.
  - A divisor of 0 or 1 gives a tick every cycle.
  - div_load latches div_value and forces the counter to div_value-1. No tick is produced in the load cycle.
  - Ticks are registered outputs.
- Byte capture:
  - A push event is the rising edge of rx_ready_in (rx_ready_in & ~rx_ready_q). Exactly one push per edge, regardless of how many cycles rx_ready_in stays high.
  - rx_data_in is sampled in the edge cycle.
- Error capture:
  - Rising edge of rx_error_in increments err_count; it saturates at 255.
  - Errored bytes are never pushed.
- FIFO:
  - Circular buffer with wrapping read/write pointers of width $clog2(DEPTH).
  - Pop occurs when m_valid & m_ready.
  - m_data always shows the head entry (show-ahead) and is valid in the same cycle m_valid is high.
  - Push into empty FIFO: m_valid=1 on the next cycle.
  - Push and pop in the same cycle: both take effect, fifo_count unchanged, including when full and when count==1.
  - Push when full with no pop: byte dropped, overflow=1, FIFO contents unchanged.
  - Pop when empty is impossible, because m_valid=0.
- Status:
  - clear_status clears overflow and err_count. If a new overflow or error occurs in the same cycle, the event wins: overflow=1 or err_count=1.
- Mid-operation reset returns everything to the reset values; the FIFO contents are discarded.
- Latency: rx_ready_in rising edge at cycle N -> m_valid/fifo_count updated at N+1.

Optional Feature:
Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - An idle counter counts baud_tick_16x pulses while the FIFO is non-empty.
  - It resets to 0 on any push, any pop, or an empty FIFO.
  - When it reaches TIMEOUT_TICKS, rx_timeout=1 (registered level) and the counter holds.
  - rx_timeout clears the cycle after the next push, pop, or empty.
- Not defined: rx_timeout is tied to 0 and no counter logic is synthesized.

Test Plan:
- DEFAULT_DIV=27, idle -> baud_tick_16x pulses exactly every 27 clk; div_load with 4 -> next tick 4 cycles after load, then every 4.
- rx_ready_in high 2 cycles with data 0xA5 -> fifo_count=1, m_valid=1, m_data=0xA5 one cycle after the edge; no duplicate push.
- Push 16 bytes 0x00..0x0F with m_ready=0, then a 17th (0xFF) -> fifo_count=16, overflow=1; drain yields 0x00..0x0F in order, 0xFF absent; pointers wrap correctly on a second fill.
- FIFO full, push 0x55 and pop in the same cycle -> count stays 16, 0x55 is the last byte read, overflow stays 0.
- 300 rx_error_in pulses -> err_count=255; clear_status coincident with an error pulse -> err_count=1.
- (UART_RX_TIMEOUT_EN) DIV=1, one byte pushed, m_ready=0 -> rx_timeout=1 after 640 ticks; pop -> rx_timeout=0 the next cycle.
